mrv1_imem_bridge: RTL and testbench

//  Sits between the instruction fetch stage and the instruction memory port. Forwards fetch

---
 rtl/mrv1_imem_bridge.sv | 105 ++++++++++
 tb/tb_mrv1_imem_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mrv1_imem_bridge.sv
// Instruction-memory bridge: forwards fetch requests to memory, tracks every
// in-flight request (pc, twid) in an in-order queue, pairs in-order responses
// with their request, and drops responses for requests killed by a flush.
module mrv1_imem_bridge #(
  parameter int unsigned NUM_TW_P          = 8,
  parameter int unsigned MAX_OUTSTANDING_P = 4,
  localparam int unsigned TwidWidth        = $clog2(NUM_TW_P),
  localparam int unsigned CntWidth         = $clog2(MAX_OUTSTANDING_P + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ifetch_req_vld_i,
  output logic                 ifetch_req_rdy_o,
  input  logic [31:0]          ifetch_req_addr_i,
  input  logic [TwidWidth-1:0] ifetch_req_twid_i,
  input  logic                 flush_i,
  output logic                 mem_req_vld_o,
  input  logic                 mem_req_rdy_i,
  output logic [31:0]          mem_req_addr_o,
  input  logic                 mem_resp_vld_i,
  input  logic [31:0]          mem_resp_data_i,
  output logic                 resp_vld_o,
  output logic [31:0]          resp_data_o,
  output logic [31:0]          resp_pc_o,
  output logic [TwidWidth-1:0] resp_twid_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 proto_err_o
);

  localparam int unsigned PtrWidth = $clog2(MAX_OUTSTANDING_P);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MAX_OUTSTANDING_P - 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(MAX_OUTSTANDING_P);

  logic [31:0]          q_pc   [MAX_OUTSTANDING_P];
  logic [TwidWidth-1:0] q_twid [MAX_OUTSTANDING_P];
  logic [MAX_OUTSTANDING_P-1:0] q_kill;

  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [CntWidth-1:0] count;
  logic                full, empty, accept, pop, deliver;

  // Request path and queue control, all from registered occupancy.
  always_comb begin
    full             = (count == CntFull);
    empty            = (count == '0);
    mem_req_vld_o    = ifetch_req_vld_i & ~full & ~flush_i;
    mem_req_addr_o   = ifetch_req_addr_i;
    ifetch_req_rdy_o = mem_req_rdy_i & ~full & ~flush_i;
    accept           = mem_req_vld_o & mem_req_rdy_i;
    pop              = mem_resp_vld_i & ~empty;
    // A flush in the pop cycle also kills the head being popped.
    deliver          = pop & ~q_kill[rd_ptr] & ~flush_i;
    outstanding_o    = count;
  end

  // Queue storage; payload needs no reset since kill/count gate its use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      q_pc[wr_ptr]   <= ifetch_req_addr_i;
      q_twid[wr_ptr] <= ifetch_req_twid_i;
    end
  end

  // Pointers, occupancy, kill bits, registered response and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      q_kill      <= '0;
      resp_vld_o  <= 1'b0;
      resp_data_o <= '0;
      resp_pc_o   <= '0;
      resp_twid_o <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (accept) begin
        q_kill[wr_ptr] <= 1'b0;
        wr_ptr         <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
      end
      // accept never coincides with flush, so this cannot fight the push above.
      if (flush_i) begin
        q_kill <= '1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !accept) begin
        count <= count - 1'b1;
      end
      resp_vld_o <= deliver;
      if (deliver) begin
        resp_data_o <= mem_resp_data_i;
        resp_pc_o   <= q_pc[rd_ptr];
        resp_twid_o <= q_twid[rd_ptr];
      end
      if (mem_resp_vld_i && empty) begin
        proto_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mrv1_imem_bridge.sv
// Randomized scoreboard bench for mrv1_imem_bridge using a queue-based
// reference model of the outstanding-request list.
module tb_mrv1_imem_bridge;

  localparam int unsigned NumTw = 8;
  localparam int unsigned Depth = 3;
  localparam int unsigned TwW   = $clog2(NumTw);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  typedef struct {
    logic [31:0]    pc;
    logic [TwW-1:0] tw;
    bit             kill;
  } ent_t;

  typedef struct {
    logic [31:0]    data;
    logic [31:0]    pc;
    logic [TwW-1:0] tw;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_vld, req_rdy, flush, mreq_vld, mreq_rdy, mresp_vld;
  logic [31:0]     req_addr, mreq_addr, mresp_data;
  logic [TwW-1:0]  req_twid, resp_twid;
  logic            resp_vld, perr;
  logic [31:0]     resp_data, resp_pc;
  logic [CntW-1:0] outst;

  int checks = 0;
  int errors = 0;

  ent_t model_q[$];
  rsp_t exp_q[$];
  bit   model_perr;

  always #5 clk = ~clk;

  mrv1_imem_bridge #(
    .NUM_TW_P         (NumTw),
    .MAX_OUTSTANDING_P(Depth)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ifetch_req_vld_i (req_vld),
    .ifetch_req_rdy_o (req_rdy),
    .ifetch_req_addr_i(req_addr),
    .ifetch_req_twid_i(req_twid),
    .flush_i          (flush),
    .mem_req_vld_o    (mreq_vld),
    .mem_req_rdy_i    (mreq_rdy),
    .mem_req_addr_o   (mreq_addr),
    .mem_resp_vld_i   (mresp_vld),
    .mem_resp_data_i  (mresp_data),
    .resp_vld_o       (resp_vld),
    .resp_data_o      (resp_data),
    .resp_pc_o        (resp_pc),
    .resp_twid_o      (resp_twid),
    .outstanding_o    (outst),
    .proto_err_o      (perr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented response must match the oldest expected one.
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resp_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual pc=%h required=none", resp_pc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_pc", resp_pc, e.pc);
          chk("resp_twid", 32'(resp_twid), 32'(e.tw));
        end
      end
    end
  end

  // One cycle of stimulus; checks request-side outputs and advances the model.
  task automatic drive(input bit vld, input logic [31:0] pc, input logic [TwW-1:0] tw,
                       input bit fl, input bit mrdy, input bit rv, input logic [31:0] rd);
    bit   full, acc;
    ent_t e;
    @(negedge clk);
    rst = 1'b0; req_vld = vld; req_addr = pc; req_twid = tw; flush = fl;
    mreq_rdy = mrdy; mresp_vld = rv; mresp_data = rd;
    #1;
    full = (model_q.size() == Depth);
    acc  = vld && !full && !fl && mrdy;
    chk("mem_req_vld", 32'(mreq_vld), 32'(vld && !full && !fl));
    chk("req_rdy", 32'(req_rdy), 32'(mrdy && !full && !fl));
    chk("mem_req_addr", mreq_addr, pc);
    chk("outstanding", 32'(outst), model_q.size());
    chk("proto_err", 32'(perr), 32'(model_perr));
    if (rv) begin
      if (model_q.size() > 0) begin
        e = model_q.pop_front();
        if (!e.kill && !fl) exp_q.push_back('{data: rd, pc: e.pc, tw: e.tw});
      end else begin
        model_perr = 1'b1;
      end
    end
    if (acc) model_q.push_back('{pc: pc, tw: tw, kill: 1'b0});
    if (fl) foreach (model_q[i]) model_q[i].kill = 1'b1;
  endtask

  task automatic idle();
    drive(0, 32'h0, '0, 0, 1, 0, 32'h0);
  endtask

  task automatic resp(input logic [31:0] d);
    drive(0, 32'h0, '0, 0, 1, 1, d);
  endtask

  task automatic req(input logic [31:0] pc, input logic [TwW-1:0] tw);
    drive(1, pc, tw, 0, 1, 0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * Depth && model_q.size() > 0; i++) resp($urandom);
    idle();
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_vld = 0; flush = 0; mreq_rdy = 0; mresp_vld = 0;
    req_addr = '0; req_twid = '0; mresp_data = '0;
    @(negedge clk);
    @(negedge clk);
    model_q.delete();
    model_perr = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_resp_vld", 32'(resp_vld), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_pc", resp_pc, 32'h0);
    chk("rst_resp_twid", 32'(resp_twid), 32'h0);
    chk("rst_outstanding", 32'(outst), 32'h0);
    chk("rst_proto_err", 32'(perr), 32'h0);

    // Single request, response two cycles later.
    req(32'h100, 3'd3);
    idle();
    resp(32'h0000_0013);
    idle();
    idle();

    // Fill the queue; further requests stall even while a response pops.
    for (int i = 0; i < Depth; i++) req(32'h1000 + 4 * i, TwW'(i));
    req(32'h2000, 3'd5);
    drive(1, 32'h2000, 3'd5, 0, 1, 1, 32'hAAAA_0001);
    req(32'h2000, 3'd5);
    drain();

    // Flush kills everything in flight; later request returns normally.
    for (int i = 0; i < 3; i++) req(32'h3000 + 4 * i, TwW'(i + 1));
    drive(0, 32'h0, '0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) resp(32'hDEAD_0000 + i);
    req(32'h200, 3'd6);
    resp(32'h1234_5678);
    idle();
    idle();

    // Flush with a response and a request in the same cycle.
    req(32'h400, 3'd2);
    req(32'h404, 3'd4);
    drive(1, 32'h408, 3'd1, 1, 1, 1, 32'hBEEF_0001);
    drain();

    // Response with empty queue sets sticky error; reset clears it.
    resp(32'h5555_5555);
    idle();
    idle();
    do_reset();
    #1;
    chk("proto_err_cleared", 32'(perr), 32'h0);

    // Randomized traffic across pointer wrap.
    for (int n = 0; n < 400; n++) begin
      bit rv;
      rv = (model_q.size() > 0) && ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, TwW'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, rv, $urandom);
    end
    drain();

    chk("exp_queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
